// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART string-frame control path: scheduler state
// encoding, frame delimiter and default downstream timeout.
package uart_ctrl_pkg;

  localparam int unsigned TMO_W = 24;
  localparam logic [TMO_W-1:0] DEF_TIMEOUT_CLK = 24'd5_000_000;

  localparam logic [7:0] DELIM_CHAR = 8'h26;  // "&"

  localparam int unsigned ST_W = 6;
  typedef logic [ST_W-1:0] state_t;

  // Bit positions of the one-hot state vector
  localparam int unsigned S_IDLE_B      = 0;
  localparam int unsigned S_GRANT_B     = 1;
  localparam int unsigned S_ISSUE_B     = 2;
  localparam int unsigned S_WAIT_BUSY_B = 3;
  localparam int unsigned S_WAIT_DONE_B = 4;
  localparam int unsigned S_RELEASE_B   = 5;

  localparam state_t S_IDLE      = 6'b000001;
  localparam state_t S_GRANT     = 6'b000010;
  localparam state_t S_ISSUE     = 6'b000100;
  localparam state_t S_WAIT_BUSY = 6'b001000;
  localparam state_t S_WAIT_DONE = 6'b010000;
  localparam state_t S_RELEASE   = 6'b100000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after
// last_grant, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    // Offset 1..NUM_REQ so last_grant itself is considered last
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one string-frame transmitter among NUM_REQ requesters: round-robin
// grant, length check, single tx_req per frame, done/timeout release.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned      NUM_REQ     = 4,
  parameter int unsigned      DATA_W      = 256,
  parameter logic [TMO_W-1:0] TIMEOUT_CLK = DEF_TIMEOUT_CLK
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_string,
  input  logic [NUM_REQ*8-1:0]      req_length,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         tx_string,
  output logic [7:0]                tx_length,
  output logic                      tx_req,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic                      sched_busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_LEN = DATA_W / 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT_CLK - TMO_W'(1);

  state_t state_q, state_d;

  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic               err_q, err_d;
  logic               done_pend_q, done_pend_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0]  tx_string_q, tx_string_d;
  logic [7:0]         tx_length_q, tx_length_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] req_done_q, req_done_d;
  logic [NUM_REQ-1:0] req_err_q, req_err_d;
  logic               tx_req_q, tx_req_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [7:0]         win_len;
  logic [DATA_W-1:0]  win_str;
  logic               len_bad;
  logic [TMO_W-1:0]   tmo_inc;
  logic               tmo_hit;
  logic [NUM_REQ-1:0] winner_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign arb_valid = |arb_grant;

  always_comb begin
    win_len = '0;
    win_str = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        win_len = req_length[i*8 +: 8];
        win_str = req_string[i*DATA_W +: DATA_W];
      end
    end
  end

  assign len_bad = (win_len == 8'd0) || (32'(win_len) > MAX_LEN);

  // Saturating increment; timeout fires on the cycle the count reaches TMO_LAST
  assign tmo_inc = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
  assign tmo_hit = (tmo_inc == TMO_LAST);

  always_comb begin
    winner_oh           = '0;
    winner_oh[winner_q] = 1'b1;
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[S_IDLE_B]: begin
        if ((|req_valid) && !tx_busy) state_d = S_GRANT;
      end
      state_q[S_GRANT_B]: begin
        if (!arb_valid)   state_d = S_IDLE;
        else if (len_bad) state_d = S_RELEASE;
        else              state_d = S_ISSUE;
      end
      state_q[S_ISSUE_B]: state_d = S_WAIT_BUSY;
      state_q[S_WAIT_BUSY_B]: begin
        if (tx_busy || tx_done) state_d = S_WAIT_DONE;
        else if (tmo_hit)       state_d = S_RELEASE;
      end
      state_q[S_WAIT_DONE_B]: begin
        if (tx_done || done_pend_q || tmo_hit) state_d = S_RELEASE;
      end
      state_q[S_RELEASE_B]: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    req_ack_d    = '0;
    req_done_d   = '0;
    req_err_d    = '0;
    tx_req_d     = 1'b0;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    err_d        = err_q;
    done_pend_d  = done_pend_q;
    tmo_cnt_d    = tmo_cnt_q;
    tx_string_d  = tx_string_q;
    tx_length_d  = tx_length_q;
    unique case (1'b1)
      state_q[S_GRANT_B]: begin
        if (arb_valid) begin
          req_ack_d    = arb_grant;
          tx_string_d  = win_str;
          tx_length_d  = win_len;
          last_grant_d = arb_idx;
          winner_d     = arb_idx;
          err_d        = len_bad;
          done_pend_d  = 1'b0;
          tmo_cnt_d    = '0;
        end
      end
      state_q[S_ISSUE_B]: tx_req_d = 1'b1;
      state_q[S_WAIT_BUSY_B]: begin
        tmo_cnt_d = tmo_inc;
        // A done that beats the busy edge is remembered, not dropped
        if (tx_done)                   done_pend_d = 1'b1;
        else if (!tx_busy && tmo_hit)  err_d       = 1'b1;
      end
      state_q[S_WAIT_DONE_B]: begin
        tmo_cnt_d = tmo_inc;
        if (tx_done || done_pend_q) err_d = 1'b0;
        else if (tmo_hit)           err_d = 1'b1;
      end
      state_q[S_RELEASE_B]: begin
        req_done_d = winner_oh;
        req_err_d  = err_q ? winner_oh : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      winner_q     <= '0;
      err_q        <= 1'b0;
      done_pend_q  <= 1'b0;
      tmo_cnt_q    <= '0;
      tx_string_q  <= '0;
      tx_length_q  <= '0;
      req_ack_q    <= '0;
      req_done_q   <= '0;
      req_err_q    <= '0;
      tx_req_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      err_q        <= err_d;
      done_pend_q  <= done_pend_d;
      tmo_cnt_q    <= tmo_cnt_d;
      tx_string_q  <= tx_string_d;
      tx_length_q  <= tx_length_d;
      req_ack_q    <= req_ack_d;
      req_done_q   <= req_done_d;
      req_err_q    <= req_err_d;
      tx_req_q     <= tx_req_d;
    end
  end

  assign req_ack    = req_ack_q;
  assign req_done   = req_done_q;
  assign req_err    = req_err_q;
  assign tx_string  = tx_string_q;
  assign tx_length  = tx_length_q;
  assign tx_req     = tx_req_q;
  assign sched_busy = !state_q[S_IDLE_B];

endmodule
